// File: rtl/div_long_small.sv
// Sequential long division of an L-limb base-MAX number by a small unsigned divisor, MS limb first.
// Optional macro DIV_LONG_ROUND_EN adds a ROUND state that rounds the quotient half-up.
module div_long_small #(
    parameter int WIDTH     = 16,
    parameter int L         = 4,
    parameter int MAX       = 10000,
    parameter int DIV_WIDTH = 16
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic                        start,
    input  logic [L-1:0][WIDTH-1:0]     a,
    input  logic [DIV_WIDTH-1:0]        d,
    output logic                        busy,
    output logic                        finish,
    output logic                        div_zero,
    output logic [L-1:0][WIDTH-1:0]     q,
    output logic [DIV_WIDTH-1:0]        rem
);

    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
    localparam int CUR_W = DIV_WIDTH + WIDTH + 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(L - 1);

    typedef logic [L-1:0][WIDTH-1:0] limbs_t;

`ifdef DIV_LONG_ROUND_EN
    typedef enum logic [1:0] {IDLE, RUN, ROUND, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t                 state_r;
    state_t                 state_nxt;
    logic                   accept;
    limbs_t                 a_r;
    logic [DIV_WIDTH-1:0]   d_r;
    logic [IDX_W-1:0]       idx;
    logic                   zero_pend;
    logic [CUR_W-1:0]       cur;
    logic [CUR_W-1:0]       dvsr;
    logic [WIDTH-1:0]       q_limb;
    logic [DIV_WIDTH-1:0]   r_limb;

`ifdef DIV_LONG_ROUND_EN
    function automatic logic round_needed(input logic [DIV_WIDTH-1:0] r,
                                          input logic [DIV_WIDTH-1:0] dv);
        return {r, 1'b0} >= {1'b0, dv};
    endfunction

    // Add one LSB with base-MAX carry; an all-(MAX-1) quotient is left as is.
    function automatic limbs_t inc_sat(input limbs_t v);
        limbs_t res;
        logic   carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < L; i++) begin
            if (carry) begin
                if (v[i] >= WIDTH'(MAX - 1)) begin
                    res[i] = '0;
                end else begin
                    res[i] = v[i] + WIDTH'(1);
                    carry  = 1'b0;
                end
            end
        end
        return carry ? v : res;
    endfunction
`endif

    // One limb step: cur = rem*MAX + a[i]; the divisor is forced non-zero so idle cycles stay defined.
    always_comb begin
        dvsr   = (d_r == '0) ? CUR_W'(1) : CUR_W'(d_r);
        cur    = CUR_W'(rem) * CUR_W'(MAX) + CUR_W'(a_r[idx]);
        q_limb = WIDTH'(cur / dvsr);
        r_limb = DIV_WIDTH'(cur % dvsr);
    end

    always_ff @(posedge ck) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        accept    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (d == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (idx == '0) begin
`ifdef DIV_LONG_ROUND_EN
                    state_nxt = ROUND;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef DIV_LONG_ROUND_EN
            ROUND: state_nxt = DONE;
`endif
            DONE: begin
                if (start && finish) begin
                    accept    = 1'b1;
                    state_nxt = (d == '0) ? RUN_OR_DONE(d) : RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    function automatic state_t RUN_OR_DONE(input logic [DIV_WIDTH-1:0] dv);
        return (dv == '0) ? DONE : RUN;
    endfunction

    always_ff @(posedge ck) begin
        if (accept) begin
            a_r <= a;
            d_r <= d;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            busy      <= 1'b0;
            finish    <= 1'b0;
            div_zero  <= 1'b0;
            q         <= '0;
            rem       <= '0;
            idx       <= IDX_TOP;
            zero_pend <= 1'b0;
        end else if (accept) begin
            busy      <= (d != '0);
            finish    <= 1'b0;
            div_zero  <= (d == '0);
            q         <= '0;
            rem       <= '0;
            idx       <= IDX_TOP;
            zero_pend <= (d == '0);
        end else begin
            case (state_r)
                RUN: begin
                    q[idx] <= q_limb;
                    rem    <= r_limb;
                    if (idx != '0) idx <= idx - IDX_W'(1);
                end
`ifdef DIV_LONG_ROUND_EN
                ROUND: begin
                    if (round_needed(rem, d_r)) q <= inc_sat(q);
                end
`endif
                // First DONE cycle settles; finish rises on the following edge and busy drops with it.
                DONE: begin
                    if (zero_pend) begin
                        zero_pend <= 1'b0;
                    end else if (!finish) begin
                        finish <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
